// File: rtl/vec_mem_seq_pkg.sv
// rtl/vec_mem_seq_pkg.sv - shared vector defines: VREG/VRAM widths, sequencer FSM encoding, beat stride
package vec_mem_seq_pkg;

  localparam int VREG_W          = 512;
  localparam int VRAM_W          = 64;
  localparam int VRAM_BEAT_BYTES = VRAM_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } vmem_state_e;

  // Byte distance between consecutive beats of one vector access.
  function automatic int beat_stride(input int beat_w);
    return beat_w / 8;
  endfunction

endpackage

// File: rtl/vec_beat_addr_gen.sv
// rtl/vec_beat_addr_gen.sv - beat byte address = base + idx*stride, wrapping modulo 2^ADDR_W
module vec_beat_addr_gen #(
  parameter int ADDR_W = 64,
  parameter int IDX_W  = 3,
  parameter int STRIDE = 8
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] offset;

  assign offset = ADDR_W'(idx_i) * ADDR_W'(STRIDE);
  assign addr_o = base_i + offset;

endmodule

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - vector load/store sequencer splitting a VLEN register into VRAM beats
// Optional byte-mask stores with zero-strobe beat skipping under macro VMEM_WMASK_EN.
module vec_mem_seq
  import vec_mem_seq_pkg::*;
#(
  parameter int VLEN   = VREG_W,
  parameter int BEAT_W = VRAM_W,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [VLEN-1:0]     req_wdata_i,
`ifdef VMEM_WMASK_EN
  input  logic [VLEN/8-1:0]   req_wmask_i,
`endif
  output logic                resp_valid_o,
  output logic [VLEN-1:0]     resp_rdata_o,
  output logic                vram_valid_o,
  input  logic                vram_ready_i,
  output logic                vram_we_o,
  output logic [ADDR_W-1:0]   vram_addr_o,
  output logic [BEAT_W-1:0]   vram_wdata_o,
  output logic [BEAT_W/8-1:0] vram_wstrb_o,
  input  logic                vram_rvalid_i,
  input  logic [BEAT_W-1:0]   vram_rdata_i
);

  localparam int NBEAT  = VLEN / BEAT_W;
  localparam int STRB_W = BEAT_W / 8;
  localparam int KW     = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int STRIDE = beat_stride(BEAT_W);
  localparam logic [KW-1:0]     K_LAST   = KW'(NBEAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LOW = ADDR_W'(STRIDE - 1);

  vmem_state_e       state_q;
  logic [KW-1:0]     k_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic [VLEN-1:0]   wdata_q;
  logic [VLEN-1:0]   rdata_q;
`ifdef VMEM_WMASK_EN
  logic [VLEN/8-1:0] mask_q;
`endif

  logic [KW-1:0]     cur_beat;
  logic              beat_found;
  logic              issue;
  logic [ADDR_W-1:0] beat_addr;

`ifdef VMEM_WMASK_EN
  // Jump straight to the next store beat with any strobe set; loads never skip.
  always_comb begin
    cur_beat   = k_q;
    beat_found = 1'b1;
    if (we_q) begin
      beat_found = 1'b0;
      for (int b = NBEAT - 1; b >= 0; b--) begin
        if (KW'(b) >= k_q && |mask_q[b*STRB_W +: STRB_W]) begin
          cur_beat   = KW'(b);
          beat_found = 1'b1;
        end
      end
    end
  end
`else
  assign cur_beat   = k_q;
  assign beat_found = 1'b1;
`endif

  vec_beat_addr_gen #(
    .ADDR_W (ADDR_W),
    .IDX_W  (KW),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .base_i (base_q),
    .idx_i  (cur_beat),
    .addr_o (beat_addr)
  );

  assign issue        = (state_q == ST_ISSUE) && beat_found;
  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_DONE);
  assign resp_rdata_o = rdata_q;
  assign vram_valid_o = issue;
  assign vram_we_o    = issue && we_q;
  assign vram_addr_o  = issue ? beat_addr : '0;
  assign vram_wdata_o = (issue && we_q) ? wdata_q[32'(cur_beat)*BEAT_W +: BEAT_W] : '0;
`ifdef VMEM_WMASK_EN
  assign vram_wstrb_o = (issue && we_q) ? mask_q[32'(cur_beat)*STRB_W +: STRB_W] : '0;
`else
  assign vram_wstrb_o = (issue && we_q) ? {STRB_W{1'b1}} : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef VMEM_WMASK_EN
      mask_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            state_q <= ST_ISSUE;
            k_q     <= '0;
            base_q  <= req_addr_i & ~ADDR_LOW;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
`ifdef VMEM_WMASK_EN
            mask_q  <= req_wmask_i;
`endif
          end
        end
        ST_ISSUE: begin
          if (!beat_found) begin
            state_q <= ST_DONE;
          end else if (vram_ready_i) begin
            if (!we_q) begin
              state_q <= ST_WAIT_R;
            end else if (cur_beat == K_LAST) begin
              state_q <= ST_DONE;
            end else begin
              k_q <= cur_beat + 1'b1;
            end
          end
        end
        ST_WAIT_R: begin
          if (vram_rvalid_i) begin
            rdata_q[32'(k_q)*BEAT_W +: BEAT_W] <= vram_rdata_i;
            if (k_q == K_LAST) begin
              state_q <= ST_DONE;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - self-checking bench for vec_mem_seq against a beat-list and memory model
module tb_vec_mem_seq;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_we_i = 1'b0;
  logic [63:0]  req_addr_i = '0;
  logic [511:0] req_wdata_i = '0;
`ifdef VMEM_WMASK_EN
  logic [63:0]  req_wmask_i = '0;
`endif
  logic         resp_valid_o;
  logic [511:0] resp_rdata_o;
  logic         vram_valid_o;
  logic         vram_ready_i = 1'b0;
  logic         vram_we_o;
  logic [63:0]  vram_addr_o;
  logic [63:0]  vram_wdata_o;
  logic [7:0]   vram_wstrb_o;
  logic         vram_rvalid_i = 1'b0;
  logic [63:0]  vram_rdata_i = '0;

  vec_mem_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
`ifdef VMEM_WMASK_EN
    .req_wmask_i   (req_wmask_i),
`endif
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .vram_valid_o  (vram_valid_o),
    .vram_ready_i  (vram_ready_i),
    .vram_we_o     (vram_we_o),
    .vram_addr_o   (vram_addr_o),
    .vram_wdata_o  (vram_wdata_o),
    .vram_wstrb_o  (vram_wstrb_o),
    .vram_rvalid_i (vram_rvalid_i),
    .vram_rdata_i  (vram_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } beat_t;

  beat_t       hs_q[$];
  logic [63:0] mem [logic [63:0]];
  logic [511:0] last_rd = '0;
  int n_vec = 0;
  int n_err = 0;
  int rd_delay = 0;
  int stall_beat = -1;
  int stall_cycles = 0;
  bit rand_ready = 0;
  bit spur_rv = 0;
  int stab_err = 0;
  int rcnt = 0;
  logic [63:0] rpend;
  bit          prev_wait = 0;
  logic [63:0] prev_addr, prev_wdata;
  logic [7:0]  prev_strb;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // VRAM responder: ready policy, beat log, delayed read data, stability watch.
  always @(negedge clk) begin
    if (!rst) begin
      rcnt = 0;
      vram_rvalid_i = 1'b0;
      vram_ready_i = 1'b1;
      prev_wait = 0;
    end else begin
      vram_rvalid_i = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          vram_rvalid_i = 1'b1;
          vram_rdata_i = rpend;
        end
      end else if (spur_rv) begin
        vram_rvalid_i = 1'b1;
        vram_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      vram_ready_i = 1'b1;
      if (rand_ready) vram_ready_i = ($urandom_range(3) != 0);
      if (vram_valid_o && hs_q.size() == stall_beat && stall_cycles > 0) begin
        vram_ready_i = 1'b0;
        stall_cycles--;
      end
      if (prev_wait && (!vram_valid_o || vram_addr_o !== prev_addr ||
                        vram_wdata_o !== prev_wdata || vram_wstrb_o !== prev_strb))
        stab_err++;
      if (vram_valid_o && vram_ready_i) begin
        hs_q.push_back('{addr: vram_addr_o, we: vram_we_o, wdata: vram_wdata_o, wstrb: vram_wstrb_o});
        if (!vram_we_o) begin
          rcnt = rd_delay + 1;
          rpend = mem_rd(vram_addr_o);
        end
        prev_wait = 0;
      end else begin
        prev_wait = vram_valid_o;
        prev_addr = vram_addr_o;
        prev_wdata = vram_wdata_o;
        prev_strb = vram_wstrb_o;
      end
    end
  end

  // One complete operation; called right after a negedge, returns after a negedge.
  task automatic do_op(input bit we, input logic [63:0] addr, input logic [511:0] wdata,
                       input logic [63:0] mask, input int exp_lat, input string tag);
    logic [63:0]  base;
    logic [511:0] exp_rd;
    beat_t        exp_q[$];
    int           cyc;
    base = addr & ~64'h7;
    exp_rd = last_rd;
    for (int k = 0; k < NB; k++) begin
      logic [7:0] s;
      s = we ? mask[k*8 +: 8] : 8'h00;
      if (!we) exp_rd[k*64 +: 64] = mem_rd(base + 64'(k * 8));
      if (!we || s != 8'h00)
        exp_q.push_back('{addr: base + 64'(k * 8), we: we, wdata: wdata[k*64 +: 64], wstrb: s});
    end
    hs_q.delete();
    chk({tag, "_ready"}, req_ready_o, 1);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_addr_i = addr;
    req_wdata_i = wdata;
`ifdef VMEM_WMASK_EN
    req_wmask_i = mask;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1;
    while (!resp_valid_o && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_resp_seen"}, resp_valid_o, 1);
    if (exp_lat >= 0) chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_done_ready"}, req_ready_o, 0);
    chk({tag, "_nbeats"}, hs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), hs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_we%0d", tag, i), hs_q[i].we, exp_q[i].we);
      chk($sformatf("%s_strb%0d", tag, i), hs_q[i].wstrb, exp_q[i].wstrb);
      if (we) chk($sformatf("%s_wdata%0d", tag, i), hs_q[i].wdata, exp_q[i].wdata);
    end
    chk({tag, "_rdata"}, resp_rdata_o, exp_rd);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, resp_valid_o, 0);
    chk({tag, "_idle"}, req_ready_o, 1);
    if (we) begin
      foreach (exp_q[i]) begin
        logic [63:0] v;
        v = mem_rd(exp_q[i].addr);
        for (int b = 0; b < 8; b++)
          if (exp_q[i].wstrb[b]) v[b*8 +: 8] = exp_q[i].wdata[b*8 +: 8];
        mem[exp_q[i].addr] = v;
      end
    end
    last_rd = exp_rd;
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0]  full_mask;
    logic [63:0]  last_st_addr;
    int           cyc;
    full_mask = '1;
    last_st_addr = 64'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_vvalid", vram_valid_o, 0);
    chk("rst_resp", resp_valid_o, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    chk("rst_addr", vram_addr_o, 0);
    chk("rst_strb", vram_wstrb_o, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NB; k++) d[k*64 +: 64] = 64'(k);
    do_op(1'b1, 64'h1000, d, full_mask, NB + 1, "st_basic");

    for (int k = 0; k < NB; k++) mem[64'h2000 + 64'(k * 8)] = 64'hA0 + 64'(k);
    rd_delay = 2;
    do_op(1'b0, 64'h2003, '0, full_mask, -1, "ld_delay");
    for (int k = 0; k < NB; k++)
      chk($sformatf("ld_slot%0d", k), resp_rdata_o[k*64 +: 64], 64'hA0 + 64'(k));
    rd_delay = 0;

    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
    do_op(1'b1, 64'h5000, d, full_mask, NB + 1, "st_hold");
    for (int k = 0; k < NB; k++)
      chk($sformatf("hold_slot%0d", k), resp_rdata_o[k*64 +: 64], 64'hA0 + 64'(k));

    do_op(1'b0, 64'h5000, '0, full_mask, 2 * NB + 1, "ld_min");

    stall_beat = 4;
    stall_cycles = 3;
    stab_err = 0;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
    do_op(1'b1, 64'h6000, d, full_mask, NB + 4, "st_stall");
    chk("stall_stable", stab_err, 0);
    stall_beat = -1;

    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
    do_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, d, full_mask, NB + 1, "st_wrap");
    chk("wrap_beat2", hs_q[2].addr, 64'h0);

    // Reset in the middle of a load: hold it low while beat 3 is being offered.
    spur_rv = 1;
    hs_q.delete();
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = 64'h3000;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 0;
    while (hs_q.size() < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached", hs_q.size(), 4);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", req_ready_o, 1);
    chk("rst_mid_vvalid", vram_valid_o, 0);
    chk("rst_mid_rdata", resp_rdata_o, 0);
    chk("rst_mid_resp", resp_valid_o, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid_o) cyc++;
    end
    chk("rst_mid_noresp", cyc, 0);
    chk("rst_mid_idle", req_ready_o, 1);
    last_rd = '0;

`ifdef VMEM_WMASK_EN
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
    do_op(1'b1, 64'h7000, d, 64'h00FF_0000_0000_FF00, -1, "mask_16");
    chk("mask_16_count", hs_q.size(), 2);
    do_op(1'b1, 64'h7100, d, 64'h0, 2, "mask_zero");
    do_op(1'b1, 64'h7200, d, 64'h0F00_00F0_3300_0081, -1, "mask_part");
    do_op(1'b0, 64'h7200, '0, full_mask, -1, "mask_ld");
`endif

    rand_ready = 1;
    for (int i = 0; i < 12; i++) begin
      logic [63:0] a;
      logic [63:0] m;
      bit          w;
      w = (i % 2 == 0);
      if (w) begin
        a = {$urandom, $urandom};
        last_st_addr = a;
      end else begin
        a = (i % 4 == 3) ? {$urandom, $urandom} : last_st_addr;
      end
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      m = full_mask;
`ifdef VMEM_WMASK_EN
      m = {$urandom, $urandom};
`endif
      rd_delay = $urandom_range(3);
      spur_rv = ($urandom_range(1) == 1);
      do_op(w, a, d, m, -1, $sformatf("rnd%0d", i));
    end
    rand_ready = 0;
    spur_rv = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "time limit");
  end

endmodule
